// File: rtl/i2s_tdm_tx.sv
// I2S / left-justified / TDM serial transmitter clocked from the master clock.
// Double-buffered frame path (holding + shadow) with underrun detection and counting.
module i2s_tdm_tx #(
    parameter int DATA_W   = 32,
    parameter int SLOT_W   = 32,
    parameter int NCH      = 2,
    parameter int MCLK_DIV = 16
) (
    input  logic                   m_clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   fmt,
    input  logic                   s_valid,
    input  logic [NCH*DATA_W-1:0]  s_data,
    output logic                   s_ready,
    output logic                   i2s_sck,
    output logic                   i2s_lrclk,
    output logic                   i2s_sdout,
    output logic                   underrun,
    output logic [15:0]            underrun_cnt
);

    localparam int FW = NCH * DATA_W;
    localparam int IW = (FW > 1) ? $clog2(FW) : 1;
    localparam int CW = $clog2(MCLK_DIV);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [SW-1:0]   slot_r;
    logic [PW-1:0]   pos_r;
    logic [FW-1:0]   hold_r;
    logic [FW-1:0]   shadow_r;
    logic            full_r;
    logic            fmt_r;
    logic            sck_r;
    logic            lrclk_r;
    logic            sdout_r;
    logic            s_ready_r;
    logic            underrun_r;
    logic [15:0]     underrun_cnt_r;

    logic            last_s;
    logic            bit_edge_s;
    logic            start_s;
    logic            boundary_s;
    logic            stop_s;
    logic            load_s;
    logic            full_nxt_s;
    logic            fmt_s;
    logic [FW-1:0]   new_frame_s;
    logic [SW-1:0]   nslot_s;
    logic [PW-1:0]   npos_s;
    logic            rem_s;
    logic            sdout_nxt_s;
    logic            lrclk_nxt_s;

    // Bit `pos` of slot `slot`: sample bits MSB first, zero padding after DATA_W.
    function automatic logic frame_bit(input logic [FW-1:0] frame, input int slot, input int pos);
        logic [IW-1:0] idx;
        if (pos >= DATA_W) begin
            return 1'b0;
        end else begin
            idx = IW'((NCH - 1 - slot) * DATA_W + DATA_W - 1 - pos);
            return frame[idx];
        end
    endfunction

    // Frame-timing decode, buffer handshake and next-bit selection.
    always_comb begin
        last_s      = (slot_r == SW'(NCH - 1)) && (pos_r == PW'(SLOT_W - 1));
        bit_edge_s  = (state_r == ST_RUN) && (cnt_r == CW'(MCLK_DIV - 1));
        start_s     = (state_r == ST_IDLE) && en;
        boundary_s  = start_s || (bit_edge_s && last_s && en);
        stop_s      = bit_edge_s && last_s && !en;
        load_s      = s_valid && s_ready_r;
        full_nxt_s  = boundary_s ? load_s : (full_r || load_s);
        new_frame_s = full_r ? hold_r : {FW{1'b0}};
        fmt_s       = boundary_s ? fmt : fmt_r;

        if (boundary_s) begin
            nslot_s = '0;
            npos_s  = '0;
        end else if (pos_r == PW'(SLOT_W - 1)) begin
            nslot_s = slot_r + SW'(1);
            npos_s  = '0;
        end else begin
            nslot_s = slot_r;
            npos_s  = pos_r + PW'(1);
        end

        // I2S lags one bit: the bit being left is the one driven next; nothing carries over from idle.
        if (start_s) begin
            rem_s = 1'b0;
        end else begin
            rem_s = frame_bit(shadow_r, int'(slot_r), int'(pos_r));
        end

        if (fmt_s) begin
            sdout_nxt_s = frame_bit(boundary_s ? new_frame_s : shadow_r, int'(nslot_s), int'(npos_s));
        end else begin
            sdout_nxt_s = rem_s;
        end

        if (NCH == 2) begin
            lrclk_nxt_s = (nslot_s != SW'(0));
        end else if (fmt_s) begin
            lrclk_nxt_s = (nslot_s == SW'(0)) && (npos_s == PW'(0));
        end else begin
            lrclk_nxt_s = (nslot_s == SW'(NCH - 1)) && (npos_s == PW'(SLOT_W - 1));
        end
    end

    // Buffers, underrun bookkeeping, divider and serial output state machine.
    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            cnt_r          <= '0;
            slot_r         <= '0;
            pos_r          <= '0;
            hold_r         <= '0;
            shadow_r       <= '0;
            full_r         <= 1'b0;
            fmt_r          <= 1'b0;
            sck_r          <= 1'b0;
            lrclk_r        <= 1'b1;
            sdout_r        <= 1'b0;
            s_ready_r      <= 1'b1;
            underrun_r     <= 1'b0;
            underrun_cnt_r <= 16'd0;
        end else begin
            if (load_s) begin
                hold_r <= s_data;
            end
            full_r     <= full_nxt_s;
            s_ready_r  <= !full_nxt_s;
            underrun_r <= boundary_s && !full_r;
            if (boundary_s) begin
                shadow_r <= new_frame_s;
                fmt_r    <= fmt;
                if (!full_r && (underrun_cnt_r != 16'hFFFF)) begin
                    underrun_cnt_r <= underrun_cnt_r + 16'd1;
                end
            end

            case (state_r)
                ST_IDLE: begin
                    cnt_r  <= '0;
                    sck_r  <= 1'b0;
                    slot_r <= '0;
                    pos_r  <= '0;
                    if (en) begin
                        state_r <= ST_RUN;
                        lrclk_r <= lrclk_nxt_s;
                        sdout_r <= sdout_nxt_s;
                    end else begin
                        lrclk_r <= 1'b1;
                        sdout_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bit_edge_s) begin
                        cnt_r <= '0;
                        sck_r <= 1'b0;
                        if (stop_s) begin
                            state_r <= ST_IDLE;
                            lrclk_r <= 1'b1;
                            sdout_r <= 1'b0;
                            slot_r  <= '0;
                            pos_r   <= '0;
                        end else begin
                            slot_r  <= nslot_s;
                            pos_r   <= npos_s;
                            lrclk_r <= lrclk_nxt_s;
                            sdout_r <= sdout_nxt_s;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                        if (cnt_r == CW'(MCLK_DIV / 2 - 1)) begin
                            sck_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready      = s_ready_r;
    assign i2s_sck      = sck_r;
    assign i2s_lrclk    = lrclk_r;
    assign i2s_sdout    = sdout_r;
    assign underrun     = underrun_r;
    assign underrun_cnt = underrun_cnt_r;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Randomized bench for i2s_tdm_tx: a stereo I2S instance and a padded TDM instance,
// each checked every m_clk cycle against a frame-level reference model.
module tb_i2s_tdm_tx;

    logic m_clk = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   fin   = 1'b0;

    always #5 m_clk = ~m_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int DW  = (g == 0) ? 32 : 12;
        localparam int SWD = (g == 0) ? 32 : 16;
        localparam int NC  = (g == 0) ? 2 : 4;
        localparam int MD  = (g == 0) ? 16 : 6;
        localparam int NB  = NC * DW;
        localparam int FB  = NC * SWD;
        localparam int P   = FB * MD;

        logic          rst_n;
        logic          en;
        logic          fmt;
        logic          s_valid;
        logic [NB-1:0] s_data;
        logic          s_ready;
        logic          i2s_sck;
        logic          i2s_lrclk;
        logic          i2s_sdout;
        logic          underrun;
        logic [15:0]   underrun_cnt;
        bit            done;

        i2s_tdm_tx #(.DATA_W(DW), .SLOT_W(SWD), .NCH(NC), .MCLK_DIV(MD)) dut (
            .m_clk(m_clk), .rst_n(rst_n), .en(en), .fmt(fmt),
            .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
            .i2s_sck(i2s_sck), .i2s_lrclk(i2s_lrclk), .i2s_sdout(i2s_sdout),
            .underrun(underrun), .underrun_cnt(underrun_cnt)
        );

        // Reference model: position in the running frame plus the two buffered frames.
        bit            run;
        int            c;
        bit            hfull;
        logic [NB-1:0] hold;
        logic [NB-1:0] cur;
        bit            prev_last;
        bit            fmt_c;
        bit            upulse;
        int            ucnt;

        function automatic bit fb(input logic [NB-1:0] fr, input int k);
            int slot;
            int pos;
            logic [NB-1:0] t;
            slot = k / SWD;
            pos  = k % SWD;
            if (pos >= DW) return 1'b0;
            t = fr >> ((NC - 1 - slot) * DW + DW - 1 - pos);
            return t[0];
        endfunction

        function automatic logic [NB-1:0] rnd();
            logic [63:0] r;
            r = {$urandom(), $urandom()};
            return r[NB-1:0];
        endfunction

        function automatic logic [NB-1:0] pat_a();
            logic [NB-1:0] a;
            a = '0;
            for (int n = 0; n < NC; n++) a = a | (NB'(n) << ((NC - 1 - n) * DW));
            if (NC == 2 && DW == 32) a = NB'(64'h80000001_7FFFFFFF);
            return a;
        endfunction

        task automatic model_reset();
            run = 0; c = 0; hfull = 0; hold = '0; cur = '0;
            prev_last = 0; fmt_c = 0; upulse = 0; ucnt = 0;
        endtask

        task automatic model_edge(input bit e, input bit f, input bit v, input logic [NB-1:0] d);
            bit bnd;
            bit rdy;
            bnd    = 0;
            rdy    = !hfull;
            upulse = 0;
            if (!run) begin
                if (e) begin
                    run = 1; c = 0; bnd = 1; prev_last = 0;
                end
            end else begin
                c++;
                if (c == P) begin
                    c = 0;
                    if (e) begin
                        bnd = 1;
                        prev_last = fb(cur, FB - 1);
                    end else begin
                        run = 0;
                    end
                end
            end
            if (bnd) begin
                fmt_c = f;
                if (hfull) begin
                    cur = hold; hfull = 0;
                end else begin
                    cur = '0; upulse = 1;
                    if (ucnt < 65535) ucnt++;
                end
            end
            if (v && rdy) begin
                hold = d; hfull = 1;
            end
        endtask

        function automatic logic [4:0] exp_pins();
            int  d;
            int  k;
            bit  sck_e;
            bit  lr_e;
            bit  sd_e;
            if (!run) return {1'b0, 1'b1, 1'b0, 1'b0, !hfull};
            d = c % MD;
            k = c / MD;
            sck_e = (d >= MD / 2);
            if (NC == 2) lr_e = (k >= SWD);
            else if (fmt_c) lr_e = (k == 0);
            else lr_e = (k == FB - 1);
            if (fmt_c) sd_e = fb(cur, k);
            else if (k == 0) sd_e = prev_last;
            else sd_e = fb(cur, k - 1);
            return {sck_e, lr_e, sd_e, upulse, !hfull};
        endfunction

        task automatic compare();
            check($sformatf("c%0d_pins{sck,lr,sd,ur,rdy}", g),
                  32'({i2s_sck, i2s_lrclk, i2s_sdout, underrun, s_ready}), 32'(exp_pins()));
            check($sformatf("c%0d_underrun_cnt", g), 32'(underrun_cnt), 32'(ucnt));
        endtask

        task automatic step(input bit e, input bit f, input bit v, input logic [NB-1:0] d);
            en = e; fmt = f; s_valid = v; s_data = d;
            @(posedge m_clk);
            model_edge(e, f, v, d);
            @(negedge m_clk);
            compare();
        endtask

        task automatic run_until(input int target);
            bit hit;
            hit = 0;
            for (int i = 0; i < 2 * P + 2; i++) begin
                if (run && c == target) begin
                    hit = 1;
                    break;
                end
                step(1'b1, fmt_c, 1'b0, '0);
            end
            if (!hit) begin
                n_vec++;
                n_err++;
                $display("FAIL c%0d_reach: frame cycle %0d never reached", g, target);
            end
        endtask

        initial begin
            bit en_v;
            bit fm_v;
            done = 0;
            rst_n = 1'b0; en = 1'b0; fmt = 1'b0; s_valid = 1'b0; s_data = '0;
            model_reset();
            repeat (3) @(negedge m_clk);
            compare();
            rst_n = 1'b1;
            repeat (4) step(1'b0, 1'b0, 1'b0, '0);

            // Directed I2S frames, then two underrun frames.
            step(1'b0, 1'b0, 1'b1, pat_a());
            step(1'b1, 1'b0, 1'b0, '0);
            step(1'b1, 1'b0, 1'b1, '0);
            repeat (3 * P) step(1'b1, 1'b0, 1'b0, '0);

            // Push lands on the very edge of an empty-holding boundary.
            run_until(P - 1);
            step(1'b1, 1'b0, 1'b1, rnd());
            repeat (2 * P) step(1'b1, 1'b0, 1'b0, '0);

            // Continuous valid in left-justified mode.
            repeat (3 * P) step(1'b1, 1'b1, 1'b1, rnd());

            // Drop en at bit 10, idle, then restart in I2S.
            run_until(10 * MD);
            repeat (2 * P) step(1'b0, 1'b0, 1'b0, '0);
            repeat (2 * P) step(1'b1, 1'b0, ($urandom_range(0, 7) == 0), rnd());

            // Random en, fmt and push traffic.
            en_v = 1'b1;
            fm_v = 1'b0;
            repeat (6 * P) begin
                if ($urandom_range(0, P - 1) == 0) en_v = !en_v;
                if ($urandom_range(0, 199) == 0) fm_v = !fm_v;
                step(en_v, fm_v, ($urandom_range(0, 3) == 0), rnd());
            end

            // Asynchronous reset in the middle of bit 40.
            run_until(40 * MD + 3);
            #2 rst_n = 1'b0;
            #1;
            model_reset();
            compare();
            @(negedge m_clk);
            compare();
            rst_n = 1'b1;
            repeat (4) step(1'b0, 1'b0, 1'b0, '0);
            done = 1;
        end
    end

    initial begin : main
        wait (cfg[0].done && cfg[1].done);
        fin = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #800000;
        if (!fin) begin
            n_vec++;
            n_err++;
            $display("FAIL watchdog: stimulus incomplete at %0t", $time);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

endmodule
